multi_ch_syn_fifo: RTL and testbench

//  Single-clock FIFO holding CH_NUM independent logical queues in one shared simple-dual-port buffer.
//  One write and one read per cycle, each steered by a channel index; per-channel counts and flags.

---
 rtl/mc_fifo_pkg.sv | 34 +++
 rtl/sdp_ram.sv | 33 +++
 rtl/multi_ch_syn_fifo.sv | 180 ++++++++++++++++++
 tb/tb_multi_ch_syn_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_fifo_pkg.sv
// Shared types and helpers for the multi-channel synchronous FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents:
//    log2()      - number of bits needed to represent a value (min 1)
//    ptr_t       - pointer/count container wide enough for any supported DEPTH
//    ch_state_t  - per-channel {wr_ptr, rd_ptr, cnt}
package mc_fifo_pkg;

   // Pointers carry a wrap bit above the address, so DEPTH may go up to 2**(PTR_MAX_W-1).
   // Unused upper bits are kept at zero by masking in the top level.
   localparam int PTR_MAX_W = 16;

   typedef logic [PTR_MAX_W-1:0] ptr_t;

   typedef struct packed {
      ptr_t wr_ptr;
      ptr_t rd_ptr;
      ptr_t cnt;
   } ch_state_t;

   // Bits needed to hold 'value' as an unsigned number; log2(7)=3, log2(8)=4.
   function automatic int log2(input int value);
      int bits;
      bits = 1;
      for (int i = 1; i < 31; i++) begin
         if ((value >> i) != 0) begin
            bits = i + 1;
         end
      end
      return bits;
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port buffer: one write port, one read port.
// Latency: read data registered, valid 1 cycle after i_rd_en; holds value when not reading.
// Backpressure: none; caller guarantees legal addresses. Contents are not reset.
// Ports:
//    i_clk                         clock
//    i_wr_en / i_wr_addr / i_wr_data  write port
//    i_rd_en / i_rd_addr           read port request
//    o_rd_data                     registered read data
module sdp_ram #(
   parameter int WIDTH = 32,
   parameter int AW    = 10
) (
   input  logic             i_clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   input  logic [AW-1:0]    i_rd_addr,
   output logic [WIDTH-1:0] o_rd_data
);

   logic [WIDTH-1:0] mem [2**AW];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem[i_wr_addr] <= i_wr_data;
      end
      if (i_rd_en) begin
         o_rd_data <= mem[i_rd_addr];
      end
   end

endmodule

// File: rtl/multi_ch_syn_fifo.sv
// CH_NUM independent FIFO queues sharing one buffer; one write and one read per cycle.
// Latency: accepted read returns data with o_rd_vld on the next cycle; flags lag ops by 1 cycle.
// Backpressure: writes to full / reads from empty are dropped and flagged as sticky errors.
// Ports:
//    i_clk, i_rst                       clock, async active-high reset
//    i_wr_en/i_wr_ch/i_wr_data          write request steered by channel
//    i_rd_en/i_rd_ch                    read request steered by channel
//    o_rd_data/o_rd_vld/o_rd_vld_ch     read response
//    i_flush                            per-channel flush pulse
//    o_full/o_almost_full/o_empty/o_almost_empty/o_data_cnt  per-channel status
//    i_clr_err, o_overflow, o_underflow sticky error flags
module multi_ch_syn_fifo
   import mc_fifo_pkg::*;
#(
   parameter  int WIDTH         = 32,
   parameter  int CH_NUM        = 4,
   parameter  int DEPTH         = 256,
   parameter  int ALM_FULL_VAL  = 192,
   parameter  int ALM_EMPTY_VAL = 64,
   localparam int CH_W          = log2(CH_NUM - 1),
   localparam int ADDR_W        = log2(DEPTH - 1),
   localparam int CNT_W         = log2(DEPTH)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_wr_en,
   input  logic [CH_W-1:0]         i_wr_ch,
   input  logic [WIDTH-1:0]        i_wr_data,
   input  logic                    i_rd_en,
   input  logic [CH_W-1:0]         i_rd_ch,
   output logic [WIDTH-1:0]        o_rd_data,
   output logic                    o_rd_vld,
   output logic [CH_W-1:0]         o_rd_vld_ch,
   input  logic [CH_NUM-1:0]       i_flush,
   output logic [CH_NUM-1:0]       o_full,
   output logic [CH_NUM-1:0]       o_almost_full,
   output logic [CH_NUM-1:0]       o_empty,
   output logic [CH_NUM-1:0]       o_almost_empty,
   output logic [CH_NUM*CNT_W-1:0] o_data_cnt,
   input  logic                    i_clr_err,
   output logic [CH_NUM-1:0]       o_overflow,
   output logic [CH_NUM-1:0]       o_underflow
);

   localparam int   AW        = CH_W + ADDR_W;
   // Pointers are ADDR_W+1 bits (wrap flag on top); the mask keeps the spare upper bits zero.
   localparam ptr_t PTR_MASK  = ptr_t'((2 * DEPTH) - 1);
   localparam ptr_t DEPTH_P   = ptr_t'(DEPTH);
   localparam ptr_t ALM_FULL  = ptr_t'(ALM_FULL_VAL);
   localparam ptr_t ALM_EMPTY = ptr_t'(ALM_EMPTY_VAL);

   ch_state_t         ch_q [CH_NUM];
   ch_state_t         ch_d [CH_NUM];
   logic [CH_NUM-1:0] ovf_q, ovf_d;
   logic [CH_NUM-1:0] udf_q, udf_d;
   logic              rd_vld_q, rd_vld_d;
   logic [CH_W-1:0]   rd_vld_ch_q, rd_vld_ch_d;
   // Buffer output is unreset; this masks it to zero until the first real read lands.
   logic              rd_seen_q, rd_seen_d;

   logic              ram_we, ram_re;
   logic [AW-1:0]     ram_waddr, ram_raddr;
   logic [WIDTH-1:0]  ram_rd_data;

   logic              wr_hit, rd_hit, full_c, empty_c, wr_acc, rd_acc;

   always_comb begin
      ch_d        = ch_q;
      // Clear first so a same-cycle error below still wins.
      ovf_d       = i_clr_err ? '0 : ovf_q;
      udf_d       = i_clr_err ? '0 : udf_q;
      rd_vld_d    = 1'b0;
      rd_vld_ch_d = rd_vld_ch_q;
      rd_seen_d   = rd_seen_q;
      ram_we      = 1'b0;
      ram_waddr   = '0;
      ram_re      = 1'b0;
      ram_raddr   = '0;
      wr_hit      = 1'b0;
      rd_hit      = 1'b0;
      full_c      = 1'b0;
      empty_c     = 1'b0;
      wr_acc      = 1'b0;
      rd_acc      = 1'b0;

      for (int c = 0; c < CH_NUM; c++) begin
         // Decoding against each legal channel ignores out-of-range indices for free.
         wr_hit  = i_wr_en && (i_wr_ch == CH_W'(c));
         rd_hit  = i_rd_en && (i_rd_ch == CH_W'(c));
         full_c  = (ch_q[c].cnt == DEPTH_P);
         empty_c = (ch_q[c].cnt == '0);
         wr_acc  = wr_hit && !full_c && !i_flush[c];
         rd_acc  = rd_hit && !empty_c && !i_flush[c];

         if (i_flush[c]) begin
            // Same-cycle traffic to a flushed channel vanishes silently.
            ch_d[c] = '0;
         end else begin
            if (wr_hit && full_c) begin
               ovf_d[c] = 1'b1;
            end
            if (rd_hit && empty_c) begin
               udf_d[c] = 1'b1;
            end
            if (wr_acc) begin
               ch_d[c].wr_ptr = (ch_q[c].wr_ptr + ptr_t'(1)) & PTR_MASK;
               ram_we         = 1'b1;
               ram_waddr      = {CH_W'(c), ch_q[c].wr_ptr[ADDR_W-1:0]};
            end
            if (rd_acc) begin
               ch_d[c].rd_ptr = (ch_q[c].rd_ptr + ptr_t'(1)) & PTR_MASK;
               ram_re         = 1'b1;
               ram_raddr      = {CH_W'(c), ch_q[c].rd_ptr[ADDR_W-1:0]};
               rd_vld_d       = 1'b1;
               rd_vld_ch_d    = CH_W'(c);
               rd_seen_d      = 1'b1;
            end
            // Modular difference of wrap-flagged pointers stays correct across wrap.
            ch_d[c].cnt = (ch_d[c].wr_ptr - ch_d[c].rd_ptr) & PTR_MASK;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int c = 0; c < CH_NUM; c++) begin
            ch_q[c] <= '0;
         end
         ovf_q       <= '0;
         udf_q       <= '0;
         rd_vld_q    <= 1'b0;
         rd_vld_ch_q <= '0;
         rd_seen_q   <= 1'b0;
      end else begin
         for (int c = 0; c < CH_NUM; c++) begin
            ch_q[c] <= ch_d[c];
         end
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         rd_vld_q    <= rd_vld_d;
         rd_vld_ch_q <= rd_vld_ch_d;
         rd_seen_q   <= rd_seen_d;
      end
   end

   sdp_ram #(
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_ram (
      .i_clk     (i_clk),
      .i_wr_en   (ram_we),
      .i_wr_addr (ram_waddr),
      .i_wr_data (i_wr_data),
      .i_rd_en   (ram_re),
      .i_rd_addr (ram_raddr),
      .o_rd_data (ram_rd_data)
   );

   always_comb begin
      o_full         = '0;
      o_almost_full  = '0;
      o_empty        = '0;
      o_almost_empty = '0;
      o_data_cnt     = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         o_full[c]                     = (ch_q[c].cnt == DEPTH_P);
         o_almost_full[c]              = (ch_q[c].cnt >= ALM_FULL);
         o_empty[c]                    = (ch_q[c].cnt == '0);
         o_almost_empty[c]             = (ch_q[c].cnt <= ALM_EMPTY);
         o_data_cnt[c*CNT_W +: CNT_W]  = ch_q[c].cnt[CNT_W-1:0];
      end
   end

   assign o_rd_data   = rd_seen_q ? ram_rd_data : '0;
   assign o_rd_vld    = rd_vld_q;
   assign o_rd_vld_ch = rd_vld_ch_q;
   assign o_overflow  = ovf_q;
   assign o_underflow = udf_q;

endmodule

// File: tb/tb_multi_ch_syn_fifo.sv
// Directed bench for multi_ch_syn_fifo with a per-channel reference queue and read scoreboard.
// Latency: expects read data on the cycle after an accepted read.
// Backpressure: models full/empty rejection and sticky error flags.
module tb_multi_ch_syn_fifo;

   localparam int DEPTH = 8;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_wr_en = 1'b0;
   logic [1:0]  i_wr_ch = '0;
   logic [31:0] i_wr_data = '0;
   logic        i_rd_en = 1'b0;
   logic [1:0]  i_rd_ch = '0;
   logic [31:0] o_rd_data;
   logic        o_rd_vld;
   logic [1:0]  o_rd_vld_ch;
   logic [3:0]  i_flush = '0;
   logic [3:0]  o_full, o_almost_full, o_empty, o_almost_empty;
   logic [15:0] o_data_cnt;
   logic        i_clr_err = 1'b0;
   logic [3:0]  o_overflow, o_underflow;

   multi_ch_syn_fifo #(
      .WIDTH         (32),
      .CH_NUM        (4),
      .DEPTH         (DEPTH),
      .ALM_FULL_VAL  (6),
      .ALM_EMPTY_VAL (2)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_wr_en        (i_wr_en),
      .i_wr_ch        (i_wr_ch),
      .i_wr_data      (i_wr_data),
      .i_rd_en        (i_rd_en),
      .i_rd_ch        (i_rd_ch),
      .o_rd_data      (o_rd_data),
      .o_rd_vld       (o_rd_vld),
      .o_rd_vld_ch    (o_rd_vld_ch),
      .i_flush        (i_flush),
      .o_full         (o_full),
      .o_almost_full  (o_almost_full),
      .o_empty        (o_empty),
      .o_almost_empty (o_almost_empty),
      .o_data_cnt     (o_data_cnt),
      .i_clr_err      (i_clr_err),
      .o_overflow     (o_overflow),
      .o_underflow    (o_underflow)
   );

   always #5 i_clk = ~i_clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   int unsigned mdl [4][$];   // reference contents per channel
   logic [33:0] sb [$];       // expected {channel, data} of read responses
   logic [3:0]  e_ovf = '0;
   logic [3:0]  e_udf = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_flags();
      logic [15:0] cnt;
      logic [3:0]  f, af, e, ae;
      cnt = '0; f = '0; af = '0; e = '0; ae = '0;
      for (int c = 0; c < 4; c++) begin
         cnt[c*4 +: 4] = 4'(mdl[c].size());
         f[c]  = (mdl[c].size() == DEPTH);
         af[c] = (mdl[c].size() >= 6);
         e[c]  = (mdl[c].size() == 0);
         ae[c] = (mdl[c].size() <= 2);
      end
      chk("data_cnt", 64'(o_data_cnt), 64'(cnt));
      chk("full", 64'(o_full), 64'(f));
      chk("almost_full", 64'(o_almost_full), 64'(af));
      chk("empty", 64'(o_empty), 64'(e));
      chk("almost_empty", 64'(o_almost_empty), 64'(ae));
      chk("overflow", 64'(o_overflow), 64'(e_ovf));
      chk("underflow", 64'(o_underflow), 64'(e_udf));
   endtask

   // One clock of stimulus; reference updated from the pre-edge state, outputs checked #1 after the edge.
   task automatic step(input logic we, input logic [1:0] wch, input logic [31:0] wd,
                       input logic re, input logic [1:0] rch, input logic [3:0] fl,
                       input logic clr);
      logic        wfull, rempty, wr_ok, rd_ok;
      int unsigned v;
      logic [33:0] ent;
      wfull  = (mdl[wch].size() == DEPTH);
      rempty = (mdl[rch].size() == 0);
      wr_ok  = we && !fl[wch] && !wfull;
      rd_ok  = re && !fl[rch] && !rempty;
      if (clr) begin
         e_ovf = '0;
         e_udf = '0;
      end
      if (we && !fl[wch] && wfull)  e_ovf[wch] = 1'b1;
      if (re && !fl[rch] && rempty) e_udf[rch] = 1'b1;
      if (rd_ok) begin
         v = mdl[rch].pop_front();
         sb.push_back({rch, v});
      end
      if (wr_ok) mdl[wch].push_back(wd);
      for (int c = 0; c < 4; c++) begin
         if (fl[c]) mdl[c].delete();
      end

      i_wr_en = we; i_wr_ch = wch; i_wr_data = wd;
      i_rd_en = re; i_rd_ch = rch; i_flush = fl; i_clr_err = clr;
      @(posedge i_clk);
      #1;
      i_wr_en = 1'b0; i_rd_en = 1'b0; i_flush = '0; i_clr_err = 1'b0;

      if (sb.size() > 0) begin
         ent = sb.pop_front();
         chk("rd_vld", 64'(o_rd_vld), 64'(1));
         chk("rd_data", 64'(o_rd_data), 64'(ent[31:0]));
         chk("rd_vld_ch", 64'(o_rd_vld_ch), 64'(ent[33:32]));
      end else begin
         chk("rd_vld_idle", 64'(o_rd_vld), 64'(0));
      end
      check_flags();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_empty"}, 64'(o_empty), 64'hF);
      chk({tag, "_almost_empty"}, 64'(o_almost_empty), 64'hF);
      chk({tag, "_full"}, 64'(o_full), 64'h0);
      chk({tag, "_almost_full"}, 64'(o_almost_full), 64'h0);
      chk({tag, "_data_cnt"}, 64'(o_data_cnt), 64'h0);
      chk({tag, "_rd_vld"}, 64'(o_rd_vld), 64'h0);
      chk({tag, "_rd_vld_ch"}, 64'(o_rd_vld_ch), 64'h0);
      chk({tag, "_rd_data"}, 64'(o_rd_data), 64'h0);
      chk({tag, "_overflow"}, 64'(o_overflow), 64'h0);
      chk({tag, "_underflow"}, 64'(o_underflow), 64'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge i_clk);
      #1;
      check_reset_outputs("reset");
      i_rst = 1'b0;

      // Fill ch2 with A0..A7, then drain in order
      for (int i = 0; i < 8; i++) step(1'b1, 2'd2, 32'hA0 + 32'(i), 1'b0, 2'd0, 4'h0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 4'h0, 1'b0);

      // Interleaved writes to ch0/ch1, then read back channel by channel
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'd0, 32'h10 + 32'(i), 1'b0, 2'd0, 4'h0, 1'b0);
         step(1'b1, 2'd1, 32'h20 + 32'(i), 1'b0, 2'd0, 4'h0, 1'b0);
      end
      for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 4'h0, 1'b0);

      // Full ch3: simultaneous write+read -> oldest out, write rejected, overflow
      for (int i = 0; i < 8; i++) step(1'b1, 2'd3, 32'h30 + 32'(i), 1'b0, 2'd0, 4'h0, 1'b0);
      step(1'b1, 2'd3, 32'hEE, 1'b1, 2'd3, 4'h0, 1'b0);
      step(1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 4'h0, 1'b1);

      // Empty ch0: simultaneous write+read -> underflow, no response, count 1
      step(1'b1, 2'd0, 32'h55, 1'b1, 2'd0, 4'h0, 1'b0);
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd0, 4'h0, 1'b1);

      // Wrap ch1 with 20 write/read pairs at depth 3
      for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 32'h40 + 32'(i), 1'b0, 2'd0, 4'h0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 2'd1, 32'h60 + 32'(i), 1'b1, 2'd1, 4'h0, 1'b0);

      // Flush ch2 holding 5 while writing it; ch1 read proceeds independently
      for (int i = 0; i < 5; i++) step(1'b1, 2'd2, 32'hB0 + 32'(i), 1'b0, 2'd0, 4'h0, 1'b0);
      step(1'b1, 2'd2, 32'h99, 1'b1, 2'd1, 4'b0100, 1'b0);
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd2, 4'h0, 1'b1);

      // Asynchronous reset mid-stream while a read response is showing
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 4'h0, 1'b0);
      #2;
      i_rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      for (int c = 0; c < 4; c++) mdl[c].delete();
      sb.delete();
      e_ovf = '0;
      e_udf = '0;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      step(1'b1, 2'd1, 32'h77, 1'b0, 2'd0, 4'h0, 1'b0);
      step(1'b0, 2'd0, 32'h0, 1'b1, 2'd1, 4'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
